cheby_horner_fx: RTL and testbench

CHEBY_HORNER_FX -- requirements
Module: cheby_horner_fx

---
 rtl/cheby_horner_fx.sv | 232 +++++++++++++++++++++++
 tb/tb_cheby_horner_fx.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheby_horner_fx.sv
// cheby_horner_fx: piecewise polynomial evaluator in signed fixed point.
// The top SEG_BITS of x pick one of 2^SEG_BITS coefficient sets. The
// polynomial is evaluated by Horner's rule, one multiply-add per clock, with
// saturation after every step. Coefficients are loaded through a simple
// write port that is only open while the evaluator is idle.
module cheby_horner_fx #(
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 12,
   parameter int N_COEF   = 4,
   parameter int SEG_BITS = 2,
   localparam int NUM_COEF = (1 << SEG_BITS) * N_COEF,
   localparam int ADDR_W   = $clog2(NUM_COEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sat,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_wdata,
   output logic              cfg_err
);

   localparam int K_W    = $clog2(N_COEF);
   localparam int PROD_W = 2 * DATA_W;
   // The sum is kept wide enough that neither the shifted product nor the
   // coefficient addition can wrap before the clamp looks at it.
   localparam int SUM_W  = PROD_W + 1;

   localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NUM_COEF);
   localparam logic [DATA_W-1:0] D_MAX    = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic [DATA_W-1:0] D_MIN    = {1'b1, {(DATA_W - 1){1'b0}}};

   // Reject configurations that the indexing arithmetic cannot cover.
   if (N_COEF < 2 || N_COEF > 16) begin : g_bad_n_coef
      $error("cheby_horner_fx: N_COEF must lie in 2..16");
   end
   if (FRAC_W >= DATA_W || SEG_BITS < 1 || SEG_BITS > DATA_W) begin : g_bad_format
      $error("cheby_horner_fx: illegal FRAC_W or SEG_BITS");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WORK  = 2'd1,
      ST_REPLY = 2'd2
   } state_t;

   state_t                    state_reg;
   state_t                    state_next;

   logic signed [DATA_W-1:0]  coef_mem [NUM_COEF];
   logic [NUM_COEF-1:0]       coef_we;

   logic signed [DATA_W-1:0]  x_reg;
   logic [SEG_BITS-1:0]       seg_reg;
   logic signed [DATA_W-1:0]  acc_reg;
   logic [K_W-1:0]            k_reg;
   logic                      sat_reg;
   logic                      cfg_err_reg;

   logic                      accept;
   logic                      cfg_wr_ok;
   logic [SEG_BITS-1:0]       in_seg;
   logic [ADDR_W-1:0]         top_idx;
   logic [ADDR_W-1:0]         work_idx;
   logic signed [DATA_W-1:0]  coef_k;

   logic signed [PROD_W-1:0]  prod;
   logic signed [PROD_W-1:0]  prod_shr;
   logic signed [SUM_W-1:0]   sum_full;
   logic                      ovf_hi;
   logic                      ovf_lo;
   logic signed [DATA_W-1:0]  acc_next;

   // ------------------------------------------------------------------
   // Handshake and coefficient-port qualification
   // ------------------------------------------------------------------
   assign accept = in_valid && in_ready;
   assign in_seg = in_data[DATA_W-1 -: SEG_BITS];

   // A write that lands on the same edge as an accept is refused so the
   // evaluation that just started sees the table exactly as it was.
   assign cfg_wr_ok = cfg_we && (state_reg == ST_IDLE) && !accept &&
                      ({1'b0, cfg_addr} < ADDR_LIM);

   for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef_we
      assign coef_we[gi] = cfg_wr_ok && (cfg_addr == ADDR_W'(gi));
   end

   // Coefficient address: segment base plus term index.
   assign top_idx  = ADDR_W'(in_seg) * ADDR_W'(N_COEF) + ADDR_W'(N_COEF - 1);
   assign work_idx = ADDR_W'(seg_reg) * ADDR_W'(N_COEF) + ADDR_W'(k_reg);
   assign coef_k   = coef_mem[work_idx];

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: a REPLY handshake may chain straight into WORK.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_WORK;
            end
         end
         ST_WORK: begin
            if (k_reg == '0) begin
               state_next = ST_REPLY;
            end
         end
         ST_REPLY: begin
            if (out_ready) begin
               state_next = accept ? ST_WORK : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake flags depend only on the state and out_ready.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_REPLY: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Horner step datapath
   // ------------------------------------------------------------------

   // One multiply-add-saturate: acc*x rescaled by floor shift, plus c[k].
   always_comb begin
      prod     = PROD_W'(acc_reg) * PROD_W'(x_reg);
      prod_shr = prod >>> FRAC_W;
      sum_full = SUM_W'(prod_shr) + SUM_W'(coef_k);
      // The sum fits DATA_W bits only if every bit above the result's sign
      // bit agrees with the true sign bit.
      ovf_hi   = !sum_full[SUM_W-1] && (|sum_full[SUM_W-2:DATA_W-1]);
      ovf_lo   = sum_full[SUM_W-1] && !(&sum_full[SUM_W-2:DATA_W-1]);
      if (ovf_hi) begin
         acc_next = D_MAX;
      end else if (ovf_lo) begin
         acc_next = D_MIN;
      end else begin
         acc_next = sum_full[DATA_W-1:0];
      end
   end

   // Evaluation registers: load on accept, iterate in WORK, hold otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_reg   <= '0;
         seg_reg <= '0;
         acc_reg <= '0;
         k_reg   <= '0;
         sat_reg <= 1'b0;
      end else if (accept) begin
         x_reg   <= in_data;
         seg_reg <= in_seg;
         acc_reg <= coef_mem[top_idx];
         k_reg   <= K_W'(N_COEF - 2);
         sat_reg <= 1'b0;
      end else if (state_reg == ST_WORK) begin
         acc_reg <= acc_next;
         sat_reg <= sat_reg | ovf_hi | ovf_lo;
         if (k_reg != '0) begin
            k_reg <= k_reg - K_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Coefficient store
   // ------------------------------------------------------------------

   // Coefficient table: cleared by reset, written one entry per cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_COEF; i++) begin
            coef_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_COEF; i++) begin
            if (coef_we[i]) begin
               coef_mem[i] <= cfg_wdata;
            end
         end
      end
   end

   // Refused writes raise a one-cycle error pulse on the following cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_err_reg <= 1'b0;
      end else begin
         cfg_err_reg <= cfg_we && !cfg_wr_ok;
      end
   end

   assign out_data = acc_reg;
   assign out_sat  = sat_reg;
   assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_cheby_horner_fx.sv
// tb_cheby_horner_fx: scoreboard bench for cheby_horner_fx.
// Stimulus pushes the expected result for every accepted x; a forked monitor
// compares whatever the DUT presents against the head of that queue.
module tb_cheby_horner_fx;

   typedef struct {
      logic [15:0] x;
      logic [15:0] d;
      logic        s;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_sat;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        cfg_err;

   // second instance with 12 coefficients so that addresses 12..15 exist
   logic        in_valid3  = 1'b0;
   logic        out_ready3 = 1'b1;
   logic [15:0] in_data3   = 16'h0000;
   logic        in_ready3;
   logic        out_valid3;
   logic [15:0] out_data3;
   logic        out_sat3;
   logic        cfg_we3;
   logic [3:0]  cfg_addr3;
   logic [15:0] cfg_wdata3;
   logic        cfg_err3;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   ready_mode = 1'b0;
   bit   ready_force = 1'b1;
   int   model_c [16];
   exp_t sb [$];

   cheby_horner_fx #(.DATA_W(16), .FRAC_W(12), .N_COEF(4), .SEG_BITS(2)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err)
   );

   cheby_horner_fx #(.DATA_W(16), .FRAC_W(12), .N_COEF(3), .SEG_BITS(2)) u_dut3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_sat(out_sat3),
      .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_wdata(cfg_wdata3), .cfg_err(cfg_err3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // consumer: random back-pressure or a fixed level, applied after the edge
   always @(posedge clk) begin
      #2;
      out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // floor(p / 2^12) written as plain integer arithmetic
   function automatic longint floor_div(input longint p);
      longint q;
      q = p / 4096;
      if (p < 0 && q * 4096 != p) q = q - 1;
      return q;
   endfunction

   // Horner evaluation of the selected segment with clamping after each step
   function automatic void model_eval(input logic [15:0] x, output logic [15:0] d, output logic s);
      longint acc;
      longint xv;
      int     seg;
      xv  = longint'($signed(x));
      seg = int'(x[15:14]);
      acc = longint'(model_c[seg * 4 + 3]);
      s   = 1'b0;
      for (int k = 2; k >= 0; k--) begin
         acc = floor_div(acc * xv) + longint'(model_c[seg * 4 + k]);
         if (acc > 32767) begin
            acc = 32767;
            s   = 1'b1;
         end else if (acc < -32768) begin
            acc = -32768;
            s   = 1'b1;
         end
      end
      d = 16'(acc);
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [15:0] x, input bit use_model,
                       input logic [15:0] d_exp, input logic s_exp);
      exp_t e;
      int   guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = x;
      @(negedge clk);
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         bound_fail("accept_timeout");
         in_valid = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      e.x   = x;
      e.cyc = cyc + 1;
      if (use_model) begin
         model_eval(x, e.d, e.s);
      end else begin
         e.d = d_exp;
         e.s = s_exp;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic send_model(input logic [15:0] x);
      send(x, 1'b1, 16'h0000, 1'b0);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (!(sb.size() == 0 && in_ready && !out_valid) && g < 500) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (!(sb.size() == 0 && in_ready && !out_valid)) bound_fail("idle_timeout");
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [15:0] d, input logic ok);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      chk($sformatf("cfg_err_pulse_a%0d", a), 32'(cfg_err), 32'(!ok));
      if (ok) model_c[a] = int'($signed(d));
      @(posedge clk);
      #1;
      chk("cfg_err_clear", 32'(cfg_err), 32'd0);
   endtask

   task automatic cfg3(input logic [3:0] a, input logic exp_err);
      cfg_we3    = 1'b1;
      cfg_addr3  = a;
      cfg_wdata3 = 16'h7777;
      @(posedge clk);
      #1;
      cfg_we3 = 1'b0;
      chk($sformatf("cfg3_err_a%0d", a), 32'(cfg_err3), 32'(exp_err));
      @(posedge clk);
      #1;
      chk("cfg3_err_clear", 32'(cfg_err3), 32'd0);
   endtask

   task automatic load_seg0_basic();
      cfg_write(4'd0, 16'h1000, 1'b1);
      cfg_write(4'd1, 16'h1000, 1'b1);
      cfg_write(4'd2, 16'h0800, 1'b1);
      cfg_write(4'd3, 16'h02AB, 1'b1);
   endtask

   // Monitor: compares every presented result, including each stalled cycle.
   task automatic run_monitor();
      bit presenting;
      presenting = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            presenting = 1'b0;
         end else if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got 0x%0h with no pending x at %0t", out_data, $time);
            end else begin
               if (!presenting) begin
                  chk("latency", 32'(cyc - sb[0].cyc), 32'd3);
                  presenting = 1'b1;
               end
               chk("out_data", 32'(out_data), 32'(sb[0].d));
               chk("out_sat", 32'(out_sat), 32'(sb[0].s));
               if (out_ready) begin
                  $display("result x=%h data=%h sat=%b", sb[0].x, out_data, out_sat);
                  void'(sb.pop_front());
                  presenting = 1'b0;
               end
            end
         end
      end
   endtask

   initial begin
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = 16'h0000;
      cfg_we     = 1'b0;
      cfg_addr   = 4'd0;
      cfg_wdata  = 16'h0000;
      cfg_we3    = 1'b0;
      cfg_addr3  = 4'd0;
      cfg_wdata3 = 16'h0000;
      for (int i = 0; i < 16; i++) model_c[i] = 0;
      fork
         run_monitor();
      join_none

      // reset state
      #7;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_sat", 32'(out_sat), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      #16;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // cleared table evaluates to zero
      send(16'h0800, 1'b0, 16'h0000, 1'b0);
      send(16'hC123, 1'b0, 16'h0000, 1'b0);
      wait_idle();

      // worked examples
      load_seg0_basic();
      send(16'h0800, 1'b0, 16'h1A55, 1'b0);
      wait_idle();
      cfg_write(4'd12, 16'h0000, 1'b1);
      cfg_write(4'd13, 16'h1000, 1'b1);
      cfg_write(4'd14, 16'h0000, 1'b1);
      cfg_write(4'd15, 16'h0000, 1'b1);
      send(16'hF000, 1'b0, 16'hF000, 1'b0);
      wait_idle();
      for (int i = 0; i < 4; i++) cfg_write(4'(i), 16'h7FFF, 1'b1);
      send(16'h0FFF, 1'b0, 16'h7FFF, 1'b1);
      wait_idle();

      // stall in REPLY for five cycles, then handshake and accept together
      ready_force = 1'b0;
      send_model(16'h1234);
      begin
         int g;
         g = 0;
         while (!out_valid && g < 20) begin
            @(posedge clk);
            #1;
            g++;
         end
         if (!out_valid) bound_fail("reply_timeout");
      end
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      ready_force = 1'b1;
      send_model(16'hC321);
      wait_idle();

      // writes refused during WORK and on the accept edge
      load_seg0_basic();
      send(16'h0800, 1'b0, 16'h1A55, 1'b0);
      cfg_write(4'd0, 16'h1234, 1'b0);
      send(16'h0800, 1'b0, 16'h1A55, 1'b0);
      wait_idle();
      cfg_we    = 1'b1;
      cfg_addr  = 4'd0;
      cfg_wdata = 16'h1234;
      send(16'h0800, 1'b0, 16'h1A55, 1'b0);
      cfg_we = 1'b0;
      chk("cfg_err_on_accept", 32'(cfg_err), 32'd1);
      @(posedge clk);
      #1;
      chk("cfg_err_on_accept_clear", 32'(cfg_err), 32'd0);
      wait_idle();
      send(16'h0800, 1'b0, 16'h1A55, 1'b0);
      wait_idle();

      // out-of-range addresses on the 12-entry instance
      cfg3(4'd12, 1'b1);
      cfg3(4'd11, 1'b0);
      cfg3(4'd15, 1'b1);
      chk("dut3_idle", {30'd0, out_valid3, in_ready3}, 32'd1);
      chk("dut3_out", {15'd0, out_sat3, out_data3}, 32'd0);

      // randomized traffic with random back-pressure
      ready_mode = 1'b1;
      for (int it = 0; it < 200; it++) begin
         if (errors > 20) break;
         if ($urandom_range(0, 9) == 0) begin
            wait_idle();
            repeat ($urandom_range(1, 4)) begin
               if ($urandom_range(0, 1) == 0)
                  cfg_write(4'($urandom_range(0, 15)), 16'($urandom), 1'b1);
               else
                  cfg_write(4'($urandom_range(0, 15)), 16'($urandom_range(0, 8191)) - 16'd4096, 1'b1);
            end
         end
         send_model(16'($urandom));
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 5)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      ready_mode  = 1'b0;
      ready_force = 1'b1;
      wait_idle();

      // reset in the middle of WORK abandons the result and clears the table
      load_seg0_basic();
      send_model(16'h0800);
      #2;
      rst = 1'b0;
      sb.delete();
      for (int i = 0; i < 16; i++) model_c[i] = 0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("no_valid_after_rst", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(16'h0800, 1'b0, 16'h0000, 1'b0);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
